// File: rtl/seri2para_pkg.sv
// seri2para_pkg: state encoding and default geometry for the serial-to-parallel collector
package seri2para_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
    localparam int WIDTH_DEF = 8;
    localparam int NWORDS_DEF = 640;
endpackage

// File: rtl/seri2para_shreg.sv
// seri2para_shreg: MSB-first shift register, bit counter and one-word skid flag
module seri2para_shreg import seri2para_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             capture,
    input  logic             bit_in,
    input  logic             stall,
    input  logic             drain,
    output logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] shreg,
    output logic             full,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    logic [BW-1:0] bitcnt;

    assign word = {shreg[WIDTH-2:0], bit_in};
    assign done = capture && bitcnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
            full   <= 1'b0;
        end else if (clr) begin
            shreg  <= '0;
            bitcnt <= '0;
            full   <= 1'b0;
        end else begin
            if (capture) begin
                shreg  <= word;
                bitcnt <= done ? '0 : bitcnt + 1'b1;
            end
            if (done && stall) full <= 1'b1;
            else if (drain) full <= 1'b0;
        end
    end
endmodule

// File: rtl/seri2para.sv
// seri2para: collects a 1-bit MSB-first stream into WIDTH-bit words delivered on valid/ready
module seri2para import seri2para_pkg::*; #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iSTART,
    input  logic             iBIT,
    input  logic             iBIT_VALID,
    input  logic             iREADY,
    output logic [WIDTH-1:0] oDATA,
    output logic             oVALID,
    output logic             oFinished,
    output logic             oOverflow,
    output logic             oBusy
);
    localparam int WW = $clog2(NWORDS + 1);
    localparam logic [WW-1:0] LASTW = WW'(NWORDS - 1);

    state_t state, state_nx;
    logic [WW-1:0] wordcnt;
    logic [WIDTH-1:0] word, shreg;
    logic full, done, run, start, accept, out_free, load_new, load_skid, load, last_load;

    assign run       = state == RUN;
    assign start     = state == IDLE && iSTART;
    assign accept    = oVALID && iREADY;
    assign out_free  = !oVALID || iREADY;
    assign load_new  = done && out_free;
    assign load_skid = run && full && out_free;
    assign load      = load_new || load_skid;
    assign last_load = load && wordcnt == LASTW;
    assign oBusy     = state == RUN || state == FLUSH;

    seri2para_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk     (iCLK),
        .rst_n   (iRST_n),
        .clr     (start),
        .capture (run && iBIT_VALID && !full),
        .bit_in  (iBIT),
        .stall   (!out_free),
        .drain   (load_skid),
        .word    (word),
        .shreg   (shreg),
        .full    (full),
        .done    (done)
    );

    always_comb begin
        state_nx = state;
        if (start) state_nx = RUN;
        else if (run && last_load) state_nx = FLUSH;
        else if (state == FLUSH && accept) state_nx = IDLE;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else state <= state_nx;
    end

    // a skid word is always older than one still arriving, so it wins the load
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wordcnt   <= '0;
            oDATA     <= '0;
            oVALID    <= 1'b0;
            oFinished <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            oFinished <= state == FLUSH && accept;
            if (start) begin
                wordcnt   <= '0;
                oOverflow <= 1'b0;
            end else begin
                if (load) wordcnt <= wordcnt + 1'b1;
                if (run && iBIT_VALID && full) oOverflow <= 1'b1;
            end
            if (load) begin
                oDATA  <= load_skid ? shreg : word;
                oVALID <= 1'b1;
            end else if (accept) oVALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seri2para.sv
// tb_seri2para: scoreboard bench for seri2para with NWORDS=2 and NWORDS=1 instances
module tb_seri2para;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic bit_in = 1'b0, bval = 1'b0, ready = 1'b1;
    logic [7:0] data_a, data_b;
    logic valid_a, fin_a, ovf_a, busy_a;
    logic valid_b, fin_b, ovf_b, busy_b;

    int total = 0, passed = 0;
    int fin_cnt_a = 0, fin_cnt_b = 0, exp_fin_a = 0, exp_fin_b = 0;
    logic [7:0] qa[$], qb[$];

    always #5 clk = ~clk;

    seri2para #(.WIDTH(8), .NWORDS(2)) dut_a (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start_a), .iBIT(bit_in), .iBIT_VALID(bval),
        .iREADY(ready), .oDATA(data_a), .oVALID(valid_a), .oFinished(fin_a),
        .oOverflow(ovf_a), .oBusy(busy_a)
    );

    seri2para #(.WIDTH(8), .NWORDS(1)) dut_b (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(start_b), .iBIT(bit_in), .iBIT_VALID(bval),
        .iREADY(ready), .oDATA(data_b), .oVALID(valid_b), .oFinished(fin_b),
        .oOverflow(ovf_b), .oBusy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // monitors: an accept happens on the next rising edge whenever valid && ready here
    always @(negedge clk) begin
        if (rst_n && valid_a && ready) begin
            if (qa.size() == 0) chk("a_unexpected_word", int'(data_a), -1);
            else chk("a_word", int'(data_a), int'(qa.pop_front()));
        end
        if (rst_n && fin_a) begin
            fin_cnt_a++;
            chk("a_busy_at_fin", int'(busy_a), 0);
        end
        if (rst_n && valid_b && ready) begin
            if (qb.size() == 0) chk("b_unexpected_word", int'(data_b), -1);
            else chk("b_word", int'(data_b), int'(qb.pop_front()));
        end
        if (rst_n && fin_b) fin_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in = v[i];
            bval = 1'b1;
            tick();
        end
        bval = 1'b0;
    endtask

    task automatic start_frame_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_fin_a();
        int k = 0;
        while (fin_cnt_a == exp_fin_a && k < 100) begin
            tick();
            k++;
        end
        exp_fin_a++;
        chk("a_fin_seen", fin_cnt_a, exp_fin_a);
        repeat (3) tick();
        chk("a_fin_once", fin_cnt_a, exp_fin_a);
        chk("a_queue_empty", qa.size(), 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_data", int'(data_a), 0);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_fin", int'(fin_a), 0);
        chk("rst_ovf", int'(ovf_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        rst_n = 1'b1;
        tick();

        // back-to-back frame, consumer always ready
        start_frame_a();
        chk("t1_busy", int'(busy_a), 1);
        qa.push_back(8'hA5);
        qa.push_back(8'hC3);
        send_bits(32'hA5, 8);
        chk("t1_latency", int'(valid_a), 1);
        send_bits(32'hC3, 8);
        wait_fin_a();
        chk("t1_ovf", int'(ovf_a), 0);
        chk("t1_idle", int'(busy_a), 0);

        // stall covers second word so it sits in the skid stage
        ready = 1'b0;
        start_frame_a();
        qa.push_back(8'hA5);
        qa.push_back(8'hC3);
        send_bits(32'hA5C3, 16);
        repeat (2) tick();
        chk("t2_valid_held", int'(valid_a), 1);
        chk("t2_data_held", int'(data_a), 8'hA5);
        ready = 1'b1;
        wait_fin_a();
        chk("t2_ovf", int'(ovf_a), 0);

        // third word dropped with output and skid both full
        ready = 1'b0;
        start_frame_a();
        qa.push_back(8'hA5);
        qa.push_back(8'hC3);
        send_bits(32'hA5C3FF, 24);
        chk("t3_ovf_set", int'(ovf_a), 1);
        tick();
        ready = 1'b1;
        wait_fin_a();
        chk("t3_ovf_sticky", int'(ovf_a), 1);

        // iSTART during RUN is ignored
        start_frame_a();
        chk("t4_ovf_cleared", int'(ovf_a), 0);
        qa.push_back(8'hA5);
        qa.push_back(8'hC3);
        send_bits(32'hA, 4);
        start_a = 1'b1;
        send_bits(32'h5, 4);
        start_a = 1'b0;
        send_bits(32'hC3, 8);
        wait_fin_a();
        chk("t4_ovf", int'(ovf_a), 0);

        // asynchronous reset mid-frame
        ready = 1'b0;
        start_frame_a();
        send_bits(32'hA5, 8);
        send_bits(32'h5, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", int'(data_a), 0);
        chk("t5_rst_valid", int'(valid_a), 0);
        chk("t5_rst_busy", int'(busy_a), 0);
        chk("t5_rst_ovf", int'(ovf_a), 0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        start_frame_a();
        qa.push_back(8'h3C);
        qa.push_back(8'h5A);
        send_bits(32'h3C, 8);
        send_bits(32'h5A, 8);
        wait_fin_a();

        // single-word frame; trailing bits ignored without overflow
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        qb.push_back(8'h96);
        send_bits(32'h96F, 12);
        begin
            int k = 0;
            while (fin_cnt_b == exp_fin_b && k < 100) begin
                tick();
                k++;
            end
        end
        exp_fin_b++;
        repeat (3) tick();
        chk("b_fin_once", fin_cnt_b, exp_fin_b);
        chk("b_ovf", int'(ovf_b), 0);
        chk("b_queue_empty", qb.size(), 0);
        chk("b_idle", int'(busy_b), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
